// File: rtl/btn_pkg.sv
// Shared types and width helpers for the push-button arbiter slice.
package btn_pkg;

  typedef enum logic [0:0] {
    IDLE,
    OFFER
  } arb_state_t;

  function automatic int ID_W(input int n_btn);
    return (n_btn > 1) ? $clog2(n_btn) : 1;
  endfunction

  // Debounce counter only ever holds 0..DB_CYCLES-1.
  function automatic int DB_W(input int db_cycles);
    return (db_cycles > 1) ? $clog2(db_cycles) : 1;
  endfunction

  // Hold counter saturates at LONG_CYCLES, so it must represent that value.
  function automatic int LONG_W(input int long_cycles);
    return (long_cycles > 0) ? $clog2(long_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, debounce, press edge and long-hold detection.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DB_CYCLES   = 16,
  parameter int LONG_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press_evt,
  output logic long_evt
);

  localparam int DBW = DB_W(DB_CYCLES);
  localparam int LW  = LONG_W(LONG_CYCLES);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [LW-1:0]  HOLD_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0]  HOLD_MAX  = LW'(LONG_CYCLES);

  logic           sync1;
  logic           sync2;
  logic [DBW-1:0] db_cnt;
  logic [LW-1:0]  hold_cnt;
  logic           flip;

  assign flip      = (sync2 != level) && (db_cnt == DB_LAST);
  // Press is flagged on the same edge that level rises, so pending sets with it.
  assign press_evt = flip && sync2;
  assign long_evt  = level && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      level  <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        db_cnt <= '0;
      end else if (flip) begin
        level  <= ~level;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
    end else if (!level) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/btn_arbiter.sv
// Debounced push-button event source: per-button pending flags, round-robin
// arbitration and a valid/ready event register.
module btn_arbiter
  import btn_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int DB_CYCLES   = 16,
  parameter int LONG_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_BTN-1:0]        btn_in,
  output logic [N_BTN-1:0]        btn_level,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [ID_W(N_BTN)-1:0]  evt_id,
  output logic                    evt_long,
  output logic                    ovf_pulse
);

  localparam int IW = ID_W(N_BTN);

  logic [N_BTN-1:0] press_evt;
  logic [N_BTN-1:0] long_evt;
  logic [N_BTN-1:0] pend_short;
  logic [N_BTN-1:0] pend_long;
  logic [N_BTN-1:0] req;
  logic [N_BTN-1:0] clr_short;
  logic [N_BTN-1:0] clr_long;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    grant_id;
  logic             grant;
  arb_state_t       state;
  arb_state_t       state_next;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .raw      (btn_in[i]),
      .level    (btn_level[i]),
      .press_evt(press_evt[i]),
      .long_evt (long_evt[i])
    );
  end

  assign req       = pend_short | pend_long;
  assign evt_valid = (state == OFFER);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_id   = '0;
    clr_short  = '0;
    clr_long   = '0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          grant      = 1'b1;
          state_next = OFFER;
          // Descending scan: the last hit is the nearest requester after ptr.
          for (int unsigned k = N_BTN; k > 0; k--) begin
            if (req[IW'((32'(ptr) + k) % N_BTN)])
              grant_id = IW'((32'(ptr) + k) % N_BTN);
          end
          clr_short[grant_id] = pend_short[grant_id];
          clr_long[grant_id]  = ~pend_short[grant_id];
        end
      end
      OFFER: begin
        if (evt_ready) state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr        <= IW'(N_BTN - 1);
      evt_id     <= '0;
      evt_long   <= 1'b0;
      pend_short <= '0;
      pend_long  <= '0;
      ovf_pulse  <= 1'b0;
    end else begin
      if (grant) begin
        evt_id   <= grant_id;
        evt_long <= ~pend_short[grant_id];
      end
      if (state == OFFER && evt_ready) ptr <= evt_id;
      // New events are OR-ed in after the grant clear, so a same-cycle set wins.
      pend_short <= (pend_short & ~clr_short) | press_evt;
      pend_long  <= (pend_long & ~clr_long) | long_evt;
      ovf_pulse  <= (|(press_evt & pend_short & ~clr_short)) |
                    (|(long_evt & pend_long & ~clr_long));
    end
  end

endmodule

// File: tb/tb_btn_arbiter.sv
// Bench for btn_arbiter: directed scenarios plus randomized buttons/ready,
// all compared against a behavioural model of the button/event rules.
module tb_btn_arbiter;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int LC = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         evt_ready = 1'b0;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic         evt_long;
  logic         ovf_pulse;

  int checks = 0;
  int failures = 0;

  btn_arbiter #(
    .N_BTN      (N),
    .DB_CYCLES  (DB),
    .LONG_CYCLES(LC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .btn_level(btn_level),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id   (evt_id),
    .evt_long (evt_long),
    .ovf_pulse(ovf_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Behavioural model: level follows the synchronized input once it has been
  // different for DB consecutive samples; events queue per button and are
  // offered one at a time, round-robin after the last accepted button.
  bit [N-1:0] m_d1, m_d2, m_lvl, m_ps, m_pl;
  bit         hist[N][$];
  int         m_rise[N];
  bit         m_valid, m_long, m_ovf;
  int         m_id, m_last;
  int         cyc = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_d1 = '0; m_d2 = '0; m_lvl = '0; m_ps = '0; m_pl = '0;
      m_valid = 0; m_long = 0; m_ovf = 0; m_id = 0; m_last = N - 1;
      for (int i = 0; i < N; i++) hist[i].delete();
    end else begin : step
      bit [N-1:0] lvl_old, press, lng, clr_s, clr_l;
      bit all_diff;
      int j;
      cyc++;
      lvl_old = m_lvl;
      press = '0; lng = '0; clr_s = '0; clr_l = '0;
      for (int i = 0; i < N; i++) begin
        if (lvl_old[i] && (cyc - m_rise[i] == LC)) lng[i] = 1;
        hist[i].push_back(m_d2[i]);
        if (hist[i].size() > DB) void'(hist[i].pop_front());
        all_diff = (hist[i].size() == DB);
        foreach (hist[i][s]) if (hist[i][s] == lvl_old[i]) all_diff = 0;
        if (all_diff) begin
          m_lvl[i] = ~lvl_old[i];
          if (m_lvl[i]) begin
            press[i] = 1;
            m_rise[i] = cyc;
          end
        end
      end
      m_d2 = m_d1;
      m_d1 = btn_in;
      if (m_valid) begin
        if (evt_ready) begin
          m_valid = 0;
          m_last = m_id;
        end
      end else if ((m_ps | m_pl) != '0) begin
        for (int k = 1; k <= N; k++) begin
          j = (m_last + k) % N;
          if (m_ps[j] || m_pl[j]) begin
            m_id = j;
            m_long = !m_ps[j];
            if (m_ps[j]) clr_s[j] = 1;
            else         clr_l[j] = 1;
            m_valid = 1;
            break;
          end
        end
      end
      m_ovf = ((press & m_ps & ~clr_s) != '0) || ((lng & m_pl & ~clr_l) != '0);
      m_ps = (m_ps & ~clr_s) | press;
      m_pl = (m_pl & ~clr_l) | lng;
    end
  end

  int   seen[$];
  int   ovf_cnt = 0;
  int   unstable = 0;
  logic p_valid = 0, p_ready = 0, p_long = 0;
  logic [1:0] p_id = '0;

  always @(negedge clk) begin
    check_eq("btn_level", 32'(btn_level), 32'(m_lvl));
    check_eq("evt_valid", 32'(evt_valid), 32'(m_valid));
    if (m_valid) begin
      check_eq("evt_id", 32'(evt_id), m_id);
      check_eq("evt_long", 32'(evt_long), 32'(m_long));
    end
    check_eq("ovf_pulse", 32'(ovf_pulse), 32'(m_ovf));
    if (reset && evt_valid && evt_ready) seen.push_back(int'(evt_id) * 2 + int'(evt_long));
    if (reset && ovf_pulse) ovf_cnt++;
    if (!reset) begin
      p_valid = 0;
    end else begin
      if (evt_valid && p_valid && !p_ready && (evt_id != p_id || evt_long != p_long))
        unstable++;
      p_valid = evt_valid; p_ready = evt_ready; p_id = evt_id; p_long = evt_long;
    end
  end

  function automatic int ev(input int i);
    return (i < seen.size()) ? seen[i] : -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [N-1:0] mask);
    btn_in = mask;
    tick(8);
    btn_in = '0;
    tick(14);
  endtask

  int rise_at;

  initial begin
    tick(3);
    reset = 1;
    tick(5);

    // Bouncing input on button 2, then stable high.
    evt_ready = 1;
    seen.delete();
    for (int c = 0; c < 12; c++) begin
      btn_in[2] = ((c / 2) % 2 == 0);
      tick(1);
    end
    btn_in[2] = 1;
    rise_at = -1;
    for (int k = 1; k <= 12 && rise_at < 0; k++) begin
      tick(1);
      if (btn_level[2]) rise_at = k;
    end
    check_eq("bounce_latency", rise_at, 6);
    tick(2);
    btn_in[2] = 0;
    tick(15);
    check_eq("bounce_count", seen.size(), 1);
    check_eq("bounce_evt", ev(0), 4);

    // Long press on button 1, twice.
    for (int r = 0; r < 2; r++) begin
      seen.delete();
      btn_in[1] = 1;
      rise_at = -1;
      for (int k = 1; k <= 20 && rise_at < 0; k++) begin
        tick(1);
        if (btn_level[1]) rise_at = k;
      end
      check_eq("long_rise_seen", 32'(rise_at > 0), 1);
      tick(20);
      btn_in[1] = 0;
      tick(15);
      check_eq("long_count", seen.size(), 2);
      check_eq("long_first_short", ev(0), 2);
      check_eq("long_second_long", ev(1), 3);
    end

    // Reset in the middle of an offer.
    evt_ready = 0;
    btn_in = 4'b1000;
    tick(10);
    check_eq("pre_rst_valid", 32'(evt_valid), 1);
    check_eq("pre_rst_id", 32'(evt_id), 3);
    reset = 0;
    #1;
    check_eq("rst_level", 32'(btn_level), 0);
    check_eq("rst_valid", 32'(evt_valid), 0);
    check_eq("rst_id", 32'(evt_id), 0);
    check_eq("rst_long", 32'(evt_long), 0);
    check_eq("rst_ovf", 32'(ovf_pulse), 0);
    btn_in = '0;
    tick(2);
    reset = 1;
    evt_ready = 1;
    seen.delete();
    tick(30);
    check_eq("rst_no_event", seen.size(), 0);

    // Round-robin order.
    seen.delete();
    press(4'b1001);
    check_eq("rr03_count", seen.size(), 2);
    check_eq("rr03_first", ev(0), 0);
    check_eq("rr03_second", ev(1), 6);
    seen.delete();
    press(4'b0011);
    check_eq("rr01_first", ev(0), 0);
    check_eq("rr01_second", ev(1), 2);
    seen.delete();
    press(4'b0110);
    check_eq("rr12_first", ev(0), 4);
    check_eq("rr12_second", ev(1), 2);

    // Backpressure and overflow on button 0.
    evt_ready = 0;
    seen.delete();
    ovf_cnt = 0;
    for (int r = 0; r < 3; r++) press(4'b0001);
    check_eq("bp_ovf_count", ovf_cnt, 1);
    evt_ready = 1;
    tick(10);
    check_eq("bp_count", seen.size(), 2);
    check_eq("bp_first", ev(0), 0);
    check_eq("bp_second", ev(1), 0);

    // New press on button 2 lands on the edge that grants button 2.
    evt_ready = 0;
    seen.delete();
    press(4'b0001);
    press(4'b0100);
    ovf_cnt = 0;
    btn_in[2] = 1;
    tick(4);
    evt_ready = 1;
    tick(2);
    btn_in = '0;
    tick(20);
    check_eq("sc_count", seen.size(), 3);
    check_eq("sc_first", ev(0), 0);
    check_eq("sc_second", ev(1), 4);
    check_eq("sc_third", ev(2), 4);
    check_eq("sc_ovf", ovf_cnt, 0);

    // Randomized buttons, ready and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) btn_in[i] = ~btn_in[i];
      evt_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 599) == 0) begin
        reset = 0;
        tick(2);
        reset = 1;
      end
      tick(1);
    end

    check_eq("offer_stable", unstable, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
